// File: rtl/lcd_hd44780_pkg.sv
// Shared constants for the HD44780 responder model: opcodes, DDRAM layout and FSM encodings.
package lcd_hd44780_pkg;

  localparam logic [7:0] CG_SPACE   = 8'h20;
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE_LEN   = 7'd16;

  // Opcode / mask pairs; a byte matches when (byte & mask) == opcode
  localparam logic [7:0] CMD_DDRAM   = 8'h80;
  localparam logic [7:0] CMD_DDRAM_M = 8'h80;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_CGRAM_M = 8'hC0;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_FUNC_M  = 8'hE0;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_SHIFT_M = 8'hF0;
  localparam logic [7:0] CMD_DISP    = 8'h08;
  localparam logic [7:0] CMD_DISP_M  = 8'hF8;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_ENTRY_M = 8'hFC;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_HOME_M  = 8'hFE;
  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_CLEAR_M = 8'hFF;

  localparam logic [1:0] S_FILL = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  function automatic logic is_cmd(input logic [7:0] d, input logic [7:0] op,
                                  input logic [7:0] mask);
    return (d & mask) == op;
  endfunction

endpackage

// File: rtl/lcd_ddram_buf.sv
// 32x8 DDRAM shadow: one synchronous write port and one registered read port.
module lcd_ddram_buf
  import lcd_hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= CG_SPACE;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780 8-bit write-bus responder: synchronises the bus, decodes instructions and
// keeps a 2x16 DDRAM shadow with address counter, entry mode and display-on state.
module lcd_hd44780_rx
  import lcd_hd44780_pkg::*;
#(
  parameter int unsigned BUSY_SHORT = 4000,
  parameter int unsigned BUSY_LONG  = 164000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       disp_on,
  output logic [6:0] addr_cnt,
  output logic       err_busy,
  output logic       err_read
);

  localparam int CNT_W = $clog2(BUSY_LONG + 1);

  logic             e_q1, e_q2, e_q3;
  logic             rs_q1, rs_q2, rw_q1, rw_q2;
  logic [7:0]       data_q1, data_q2;
  logic             xfer;
  logic [1:0]       state;
  logic [4:0]       fill_idx;
  logic [CNT_W-1:0] cnt;
  logic             inc;
  logic             we;
  logic [4:0]       waddr;
  logic [7:0]       wdata;

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    if (up) begin
      if (ac == LINE1_BASE + 7'h27) return LINE2_BASE;
      if (ac == LINE2_BASE + 7'h27) return LINE1_BASE;
      return ac + 7'd1;
    end
    if (ac == LINE1_BASE) return LINE2_BASE + 7'h27;
    if (ac == LINE2_BASE) return LINE1_BASE + 7'h27;
    return ac - 7'd1;
  endfunction

  // Addresses past column 0x27 of either line do not exist and collapse to 0
  function automatic logic [6:0] ddram_target(input logic [6:0] a);
    return (a[5] && (a[4] || a[3])) ? 7'h00 : a;
  endfunction

  function automatic logic ac_visible(input logic [6:0] ac);
    return ((ac - LINE1_BASE) < LINE_LEN) || ((ac - LINE2_BASE) < LINE_LEN);
  endfunction

  // Bus synchroniser: all bus signals share the same depth so they stay aligned with E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {e_q1, e_q2, e_q3}   <= 3'b000;
      {rs_q1, rs_q2}       <= 2'b00;
      {rw_q1, rw_q2}       <= 2'b00;
      {data_q1, data_q2}   <= 16'h0000;
    end else begin
      {e_q1, e_q2, e_q3}   <= {lcd_e, e_q1, e_q2};
      {rs_q1, rs_q2}       <= {lcd_rs, rs_q1};
      {rw_q1, rw_q2}       <= {lcd_rw, rw_q1};
      {data_q1, data_q2}   <= {lcd_data, data_q1};
    end
  end

  assign xfer = !e_q2 && e_q3;
  assign busy = (state != S_IDLE);

  always_comb begin
    we    = 1'b0;
    waddr = fill_idx;
    wdata = CG_SPACE;
    if (state == S_FILL) begin
      we = 1'b1;
    end else if (state == S_IDLE && xfer && !rw_q2 && rs_q2 && ac_visible(addr_cnt)) begin
      we    = 1'b1;
      waddr = {addr_cnt[6], addr_cnt[3:0]};
      wdata = data_q2;
    end
  end

  // Entry-mode S (display shift) has no effect on the shadow, so only I/D is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FILL;
      fill_idx <= 5'd0;
      cnt      <= '0;
      addr_cnt <= 7'h00;
      inc      <= 1'b1;
      disp_on  <= 1'b0;
      err_busy <= 1'b0;
      err_read <= 1'b0;
    end else begin
      if (xfer && state != S_IDLE) begin
        err_busy <= 1'b1;
        if (rw_q2) err_read <= 1'b1;
      end
      case (state)
        S_FILL: begin
          fill_idx <= fill_idx + 5'd1;
          if (fill_idx == 5'd31) state <= S_BUSY;
        end
        S_BUSY: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        S_IDLE: begin
          if (xfer && rw_q2) begin
            err_read <= 1'b1;
          end else if (xfer) begin
            state <= S_BUSY;
            cnt   <= CNT_W'(BUSY_SHORT);
            if (rs_q2) begin
              addr_cnt <= ac_step(addr_cnt, inc);
            end else if (is_cmd(data_q2, CMD_DDRAM, CMD_DDRAM_M)) begin
              addr_cnt <= ddram_target(data_q2[6:0]);
            end else if (is_cmd(data_q2, CMD_SHIFT, CMD_SHIFT_M)) begin
              if (!data_q2[3]) addr_cnt <= ac_step(addr_cnt, data_q2[2]);
            end else if (is_cmd(data_q2, CMD_DISP, CMD_DISP_M)) begin
              disp_on <= data_q2[2];
            end else if (is_cmd(data_q2, CMD_ENTRY, CMD_ENTRY_M)) begin
              inc <= data_q2[1];
            end else if (is_cmd(data_q2, CMD_HOME, CMD_HOME_M)) begin
              addr_cnt <= LINE1_BASE;
              cnt      <= CNT_W'(BUSY_LONG);
            end else if (is_cmd(data_q2, CMD_CLEAR, CMD_CLEAR_M)) begin
              state    <= S_FILL;
              fill_idx <= 5'd0;
              addr_cnt <= LINE1_BASE;
              inc      <= 1'b1;
              cnt      <= CNT_W'(BUSY_LONG);
            end
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  lcd_ddram_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Directed bench for lcd_hd44780_rx with shortened busy periods.
module tb_lcd_hd44780_rx;

  localparam int unsigned BUSY_SHORT = 40;
  localparam int unsigned BUSY_LONG  = 1640;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       busy, disp_on, err_busy, err_read;
  logic [6:0] addr_cnt;

  int checks = 0;
  int fails  = 0;

  lcd_hd44780_rx #(.BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)) dut (
    .clk(clk), .reset(reset), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .busy(busy),
    .disp_on(disp_on), .addr_cnt(addr_cnt), .err_busy(err_busy), .err_read(err_read)
  );

  always #5 clk = ~clk;

  // One bus cycle; returns after the responder has had time to act on the E fall
  task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) begin
      checks++; fails++;
      $display("FAIL %s: busy still 1 after %0d cycles, required 0", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    bus_write(rs, 1'b0, d);
    wait_idle("send_wait");
  endtask

  task automatic read_cell(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(idx);
    @(negedge clk);
    v = rd_char;
  endtask

  task automatic check_all_blank(input string name);
    logic [7:0] v;
    for (int i = 0; i < 32; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== 8'h20) begin
        fails++;
        $display("FAIL %s cell %0d: got %h, required 20", name, i, v);
      end
    end
  endtask

  task automatic count_reset_busy(input string name);
    int n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n !== 33) begin
      fails++;
      $display("FAIL %s: busy lasted %0d cycles, required 33", name, n);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, disp_on, addr_cnt, err_busy, err_read, rd_char} !== {1'b1, 1'b0, 7'h00, 1'b0, 1'b0, 8'h20}) begin
      fails++;
      $display("FAIL reset_state: busy=%b disp=%b ac=%h eb=%b er=%b rd=%h, required 1 0 00 0 0 20",
               busy, disp_on, addr_cnt, err_busy, err_read, rd_char);
    end
    reset = 1'b0;
    count_reset_busy("reset_busy_len");
    check_all_blank("reset_fill");
  endtask

  task automatic test_init;
    logic [7:0] seq [6] = '{8'h38, 8'h08, 8'h01, 8'h06, 8'h0C, 8'h02};
    for (int i = 0; i < 6; i++) send(1'b0, seq[i]);
    checks++;
    if ({disp_on, addr_cnt, err_busy, err_read} !== {1'b1, 7'h00, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL init_seq: disp=%b ac=%h eb=%b er=%b, required 1 00 0 0",
               disp_on, addr_cnt, err_busy, err_read);
    end
  endtask

  task automatic test_line1;
    logic [7:0] s [10] = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h2F, 8'h30, 8'h31, 8'h2F, 8'h30, 8'h31};
    logic [7:0] v;
    send(1'b0, 8'h80);
    for (int i = 0; i < 10; i++) send(1'b1, s[i]);
    for (int i = 0; i < 10; i++) begin
      read_cell(i, v);
      checks++;
      if (v !== s[i]) begin
        fails++;
        $display("FAIL line1 cell %0d: got %h, required %h", i, v, s[i]);
      end
    end
    checks++;
    if (addr_cnt !== 7'h0A) begin
      fails++;
      $display("FAIL line1_ac: got %h, required 0a", addr_cnt);
    end
  endtask

  task automatic test_line2;
    logic [7:0] s [8] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h31};
    logic [7:0] v;
    send(1'b0, 8'hC0);
    for (int i = 0; i < 8; i++) send(1'b1, s[i]);
    for (int i = 0; i < 8; i++) begin
      read_cell(16 + i, v);
      checks++;
      if (v !== s[i]) begin
        fails++;
        $display("FAIL line2 cell %0d: got %h, required %h", 16 + i, v, s[i]);
      end
    end
    checks++;
    if (addr_cnt !== 7'h48) begin
      fails++;
      $display("FAIL line2_ac: got %h, required 48", addr_cnt);
    end
    send(1'b0, 8'hA7);
    send(1'b1, 8'h41);
    checks++;
    if (addr_cnt !== 7'h40) begin
      fails++;
      $display("FAIL wrap_27_to_40: got %h, required 40", addr_cnt);
    end
    read_cell(24, v);
    checks++;
    if (v !== 8'h20) begin
      fails++;
      $display("FAIL dropped_write cell 24: got %h, required 20", v);
    end
    send(1'b1, 8'h42);
    read_cell(16, v);
    checks++;
    if (v !== 8'h42 || addr_cnt !== 7'h41) begin
      fails++;
      $display("FAIL after_wrap_write: cell16=%h ac=%h, required 42 41", v, addr_cnt);
    end
  endtask

  task automatic test_ac_bounds;
    logic [7:0] v;
    send(1'b0, 8'hB0);
    checks++;
    if (addr_cnt !== 7'h00) begin
      fails++;
      $display("FAIL ddram_forced_zero: got %h, required 00", addr_cnt);
    end
    send(1'b0, 8'h04);
    send(1'b1, 8'h51);
    read_cell(0, v);
    checks++;
    if (v !== 8'h51 || addr_cnt !== 7'h67) begin
      fails++;
      $display("FAIL dec_wrap_00_to_67: cell0=%h ac=%h, required 51 67", v, addr_cnt);
    end
    send(1'b0, 8'h14);
    checks++;
    if (addr_cnt !== 7'h00) begin
      fails++;
      $display("FAIL shift_inc_67_to_00: got %h, required 00", addr_cnt);
    end
    send(1'b0, 8'hC0);
    send(1'b0, 8'h10);
    checks++;
    if (addr_cnt !== 7'h27) begin
      fails++;
      $display("FAIL shift_dec_40_to_27: got %h, required 27", addr_cnt);
    end
    send(1'b0, 8'h1C);
    checks++;
    if (addr_cnt !== 7'h27) begin
      fails++;
      $display("FAIL display_shift_no_ac: got %h, required 27", addr_cnt);
    end
    send(1'b0, 8'h08);
    checks++;
    if (disp_on !== 1'b0) begin
      fails++;
      $display("FAIL display_off: got %b, required 0", disp_on);
    end
    send(1'b0, 8'h0C);
    send(1'b0, 8'h06);
  endtask

  task automatic test_clear_busy;
    bus_write(1'b0, 1'b0, 8'h01);
    repeat (1000) @(negedge clk);
    bus_write(1'b1, 1'b0, 8'h58);
    checks++;
    if (err_busy !== 1'b1 || err_read !== 1'b0) begin
      fails++;
      $display("FAIL err_busy_set: eb=%b er=%b, required 1 0", err_busy, err_read);
    end
    wait_idle("clear_wait");
    check_all_blank("clear_fill");
    checks++;
    if (addr_cnt !== 7'h00) begin
      fails++;
      $display("FAIL clear_ac: got %h, required 00", addr_cnt);
    end
  endtask

  task automatic test_read_err;
    bus_write(1'b0, 1'b1, 8'h85);
    checks++;
    if (err_read !== 1'b1 || busy !== 1'b0 || addr_cnt !== 7'h00) begin
      fails++;
      $display("FAIL read_flag: er=%b busy=%b ac=%h, required 1 0 00", err_read, busy, addr_cnt);
    end
  endtask

  task automatic test_reset_during_fill;
    send(1'b1, 8'h5A);
    send(1'b0, 8'h8C);
    send(1'b1, 8'h59);
    bus_write(1'b0, 1'b0, 8'h01);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, err_busy, err_read, addr_cnt} !== {1'b1, 1'b0, 1'b0, 7'h00}) begin
      fails++;
      $display("FAIL reset_mid_fill: busy=%b eb=%b er=%b ac=%h, required 1 0 0 00",
               busy, err_busy, err_read, addr_cnt);
    end
    reset = 1'b0;
    count_reset_busy("refill_busy_len");
    check_all_blank("refill");
  endtask

  initial begin
    test_reset();
    test_init();
    test_line1();
    test_line2();
    test_ac_bounds();
    test_clear_busy();
    test_read_err();
    test_reset_during_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
